mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data memory) arbiter for a
// single-ported synchronous memory. One transaction at a time runs through
// IDLE -> ACCESS -> RESP, and a one-cycle done pulse follows in IDLE.
// Simultaneous requests are resolved round-robin on the last owner.
//
// Ports:
//   clk, rst_f               clock, synchronous active-low reset
//   if_req, if_addr          fetch request (level) and word address
//   dm_req, dm_we, dm_addr,
//   dm_wdata                 data request (level), store flag, address, data
//   mem_rdata                memory read data, valid the cycle after mem_en
//   mem_en, mem_we,
//   mem_addr, mem_wdata      memory access strobe, write enable, address, data
//   if_gnt, dm_gnt           owner's grant during ACCESS
//   if_done, dm_done         one-cycle completion pulse
//   if_rdata, dm_rdata       per-requester registered read data
//   busy                     high whenever a transaction is in flight
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        if_gnt,
  output logic        dm_gnt,
  output logic        if_done,
  output logic        dm_done,
  output logic [31:0] if_rdata,
  output logic [31:0] dm_rdata,
  output logic        busy
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          owner, owner_n;            // 1 = DM, 0 = fetch
  logic          last_owner, last_owner_n;  // 1 = DM, 0 = fetch
  logic          lat_we, lat_we_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n, if_rdata_n, dm_rdata_n;
  logic          mem_en_n, mem_we_n, if_gnt_n, dm_gnt_n;
  logic          if_done_n, dm_done_n, busy_n;
  logic          if_vld_c, dm_vld_c, pick_dm_c;

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    lat_we_n     = lat_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    if_rdata_n   = if_rdata;
    dm_rdata_n   = dm_rdata;
    mem_en_n     = 1'b0;
    mem_we_n     = 1'b0;
    if_gnt_n     = 1'b0;
    dm_gnt_n     = 1'b0;
    if_done_n    = 1'b0;
    dm_done_n    = 1'b0;

    // A requester completing this cycle is masked so a held req cannot re-win immediately
    if_vld_c  = if_req & ~if_done;
    dm_vld_c  = dm_req & ~dm_done;
    pick_dm_c = dm_vld_c & (~if_vld_c | ~last_owner);

    case (state)
      S_IDLE: begin
        if (if_vld_c | dm_vld_c) begin
          state_n      = S_ACCESS;
          owner_n      = pick_dm_c;
          last_owner_n = pick_dm_c;
          mem_en_n     = 1'b1;
          if_gnt_n     = ~pick_dm_c;
          dm_gnt_n     = pick_dm_c;
          if (pick_dm_c) begin
            mem_addr_n  = dm_addr;
            mem_wdata_n = dm_wdata;
            lat_we_n    = dm_we;
            mem_we_n    = dm_we;
          end else begin
            mem_addr_n  = if_addr;
            lat_we_n    = 1'b0;
          end
        end
      end
      S_ACCESS: begin
        state_n = S_RESP;
      end
      S_RESP: begin
        state_n = S_IDLE;
        if (!lat_we) begin
          if (owner) dm_rdata_n = mem_rdata;
          else       if_rdata_n = mem_rdata;
        end
        if_done_n = ~owner;
        dm_done_n = owner;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lat_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      lat_we     <= lat_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      if_rdata   <= if_rdata_n;
      dm_rdata   <= dm_rdata_n;
      mem_en     <= mem_en_n;
      mem_we     <= mem_we_n;
      if_gnt     <= if_gnt_n;
      dm_gnt     <= dm_gnt_n;
      if_done    <= if_done_n;
      dm_done    <= dm_done_n;
      busy       <= busy_n;
    end
  end

endmodule
